// File: rtl/ctrl_bin_sched_if.sv
// Handshake bundle between the bin scheduler (master) and the engine loader,
// ctrl_core, global store and backtrack agents (slave).
interface ctrl_bin_sched_if #(
    parameter int WIDTH_BIN = 16
);
    logic                 start_load_o;
    logic [WIDTH_BIN-1:0] load_bin_num_o;
    logic                 done_load_i;
    logic                 core_clr_o;
    logic                 start_core_o;
    logic                 done_core_i;
    logic                 sat_i;
    logic                 unsat_i;
    logic [WIDTH_BIN-1:0] bkt_bin_num_i;
    logic                 start_store_o;
    logic                 done_store_i;
    logic                 apply_bkt_o;
    logic                 done_bkt_i;
    logic [WIDTH_BIN-1:0] cur_bin_num_o;

    modport master (
        output start_load_o, load_bin_num_o, core_clr_o, start_core_o,
               start_store_o, apply_bkt_o, cur_bin_num_o,
        input  done_load_i, done_core_i, sat_i, unsat_i, bkt_bin_num_i,
               done_store_i, done_bkt_i
    );

    modport slave (
        input  start_load_o, load_bin_num_o, core_clr_o, start_core_o,
               start_store_o, apply_bkt_o, cur_bin_num_o,
        output done_load_i, done_core_i, sat_i, unsat_i, bkt_bin_num_i,
               done_store_i, done_bkt_i
    );
endinterface

// File: rtl/ctrl_bin_sched.sv
// Bin-level scheduler: walks bins through load / clear / solve / store, advancing on sat
// and jumping to the backtrack bin on unsat, until global SAT or UNSAT is reached.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start_i
// LOAD      | start_load_o pulse for cur_bin
// WAIT_LD   | waiting for done_load_i
// CLR       | core_clr_o pulse (clears ctrl_core sticky flags)
// START     | start_core_o pulse
// WAIT_CORE | waiting for ctrl_core verdict
// STORE     | start_store_o pulse for cur_bin
// WAIT_ST   | waiting for done_store_i, then decide next bin / finish
// BKT       | apply_bkt_o held until done_bkt_i
// FINISH    | done_o and verdict flags sticky; start_i restarts
module ctrl_bin_sched #(
    parameter int WIDTH_BIN = 16,
    parameter int WIDTH_CNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH_BIN-1:0] num_bins_i,
    ctrl_bin_sched_if.master     bus,
    output logic                 global_sat_o,
    output logic                 global_unsat_o,
    output logic                 done_o,
    output logic [WIDTH_CNT-1:0] cycle_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LD,
        S_CLR,
        S_START,
        S_WAIT_CORE,
        S_STORE,
        S_WAIT_ST,
        S_BKT,
        S_FINISH
    } state_t;

    state_t               state_q;
    logic [WIDTH_BIN-1:0] num_bins_q;
    logic [WIDTH_BIN-1:0] cur_bin_q;
    logic [WIDTH_BIN-1:0] bkt_q;
    logic                 unsat_q;
    logic                 start_load_q;
    logic                 core_clr_q;
    logic                 start_core_q;
    logic                 start_store_q;
    logic                 apply_bkt_q;
    logic                 gsat_q;
    logic                 gunsat_q;
    logic                 done_q;
    logic [WIDTH_CNT-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            num_bins_q    <= '0;
            cur_bin_q     <= '0;
            bkt_q         <= '0;
            unsat_q       <= 1'b0;
            start_load_q  <= 1'b0;
            core_clr_q    <= 1'b0;
            start_core_q  <= 1'b0;
            start_store_q <= 1'b0;
            apply_bkt_q   <= 1'b0;
            gsat_q        <= 1'b0;
            gunsat_q      <= 1'b0;
            done_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            start_load_q  <= 1'b0;
            core_clr_q    <= 1'b0;
            start_core_q  <= 1'b0;
            start_store_q <= 1'b0;

            if (state_q != S_IDLE && state_q != S_FINISH && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end

            unique case (state_q)
                S_IDLE, S_FINISH: begin
                    if (start_i) begin
                        // a zero bin count would never match cur_bin, so run it as one bin
                        num_bins_q   <= (num_bins_i == '0) ? WIDTH_BIN'(1) : num_bins_i;
                        cur_bin_q    <= WIDTH_BIN'(1);
                        gsat_q       <= 1'b0;
                        gunsat_q     <= 1'b0;
                        done_q       <= 1'b0;
                        cnt_q        <= '0;
                        start_load_q <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: state_q <= S_WAIT_LD;
                S_WAIT_LD: begin
                    if (bus.done_load_i) begin
                        core_clr_q <= 1'b1;
                        state_q    <= S_CLR;
                    end
                end
                S_CLR: begin
                    start_core_q <= 1'b1;
                    state_q      <= S_START;
                end
                S_START: state_q <= S_WAIT_CORE;
                S_WAIT_CORE: begin
                    // a simultaneous sat/unsat is resolved as unsat
                    if (bus.done_core_i && (bus.sat_i || bus.unsat_i)) begin
                        unsat_q       <= bus.unsat_i;
                        if (bus.unsat_i) begin
                            bkt_q <= bus.bkt_bin_num_i;
                        end
                        start_store_q <= 1'b1;
                        state_q       <= S_STORE;
                    end
                end
                S_STORE: state_q <= S_WAIT_ST;
                S_WAIT_ST: begin
                    if (bus.done_store_i) begin
                        if (!unsat_q) begin
                            if (cur_bin_q == num_bins_q) begin
                                gsat_q  <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                cur_bin_q    <= cur_bin_q + 1'b1;
                                start_load_q <= 1'b1;
                                state_q      <= S_LOAD;
                            end
                        end else if (bkt_q == '0) begin
                            gunsat_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_FINISH;
                        end else begin
                            cur_bin_q   <= bkt_q;
                            apply_bkt_q <= 1'b1;
                            state_q     <= S_BKT;
                        end
                    end
                end
                S_BKT: begin
                    if (bus.done_bkt_i) begin
                        apply_bkt_q  <= 1'b0;
                        start_load_q <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.start_load_o   = start_load_q;
    assign bus.load_bin_num_o = cur_bin_q;
    assign bus.core_clr_o     = core_clr_q;
    assign bus.start_core_o   = start_core_q;
    assign bus.start_store_o  = start_store_q;
    assign bus.apply_bkt_o    = apply_bkt_q;
    assign bus.cur_bin_num_o  = cur_bin_q;
    assign global_sat_o       = gsat_q;
    assign global_unsat_o     = gunsat_q;
    assign done_o             = done_q;
    assign cycle_cnt_o        = cnt_q;

endmodule
